// File: rtl/keypad_scanner_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
package gomoku_kb_pkg;

  typedef logic [3:0] key_code_t;

  typedef enum logic [1:0] {
    KB_IDLE       = 2'd0,
    KB_DB_PRESS   = 2'd1,
    KB_HELD       = 2'd2,
    KB_DB_RELEASE = 2'd3
  } kb_state_e;

  typedef enum logic [1:0] {
    SCAN_NONE   = 2'd0,
    SCAN_SINGLE = 2'd1,
    SCAN_MULTI  = 2'd2
  } scan_kind_e;

  typedef struct packed {
    scan_kind_e kind;
    logic [1:0] idx;
  } row_dec_t;

  // Codes at or above this value are X coordinates, below are Y.
  localparam int KEY_X_BASE = 8;

  // Active-low column drive pattern for column index idx (0 -> 0111).
  function automatic logic [3:0] col_drive(input logic [1:0] idx);
    return ~(4'b1000 >> idx);
  endfunction

  // Classify one active-low row sample: no key, one row, or several rows.
  function automatic row_dec_t row_decode(input logic [3:0] row);
    row_dec_t d;
    d.kind = SCAN_MULTI;
    d.idx  = 2'd0;
    case (row)
      4'b0111: begin d.kind = SCAN_SINGLE; d.idx = 2'd0; end
      4'b1011: begin d.kind = SCAN_SINGLE; d.idx = 2'd1; end
      4'b1101: begin d.kind = SCAN_SINGLE; d.idx = 2'd2; end
      4'b1110: begin d.kind = SCAN_SINGLE; d.idx = 2'd3; end
      4'b1111: begin d.kind = SCAN_NONE;   d.idx = 2'd0; end
      default: begin d.kind = SCAN_MULTI;  d.idx = 2'd0; end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad-side and consumer-side signals of the keypad scanner.
import gomoku_kb_pkg::*;

interface keypad_scanner_if;
  logic [3:0] keyboard_row;
  logic [3:0] keyboard_col;
  logic       key_valid;
  key_code_t  key_code;
  logic       key_down;

  modport master (
    input  keyboard_row,
    output keyboard_col,
    output key_valid,
    output key_code,
    output key_down
  );

  modport slave (
    output keyboard_row,
    input  keyboard_col,
    input  key_valid,
    input  key_code,
    input  key_down
  );
endinterface

// File: rtl/keypad_scanner_column_scan.sv
// Column walker: drives one column low at a time, samples the rows at the end
// of each dwell and folds the four samples into one per-scan result.
module kb_column_scan
  import gomoku_kb_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] i_row,
  output logic [3:0] o_col,
  output logic       o_scan_done,
  output scan_kind_e o_scan_kind,
  output key_code_t  o_scan_code
);

  localparam int PW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam logic [PW-1:0] PHASE_LAST = PW'(SETTLE_CYCLES);

  logic [PW-1:0] r_phase;
  logic [1:0]    r_col_idx;
  logic [3:0]    r_col;
  scan_kind_e    r_acc_kind;
  key_code_t     r_acc_code;

  logic       w_sample;
  logic [1:0] w_col_idx_nxt;
  row_dec_t   w_dec;
  scan_kind_e w_kind;
  key_code_t  w_code;

  assign w_sample      = (r_phase == PHASE_LAST);
  assign w_col_idx_nxt = r_col_idx + 2'd1;
  assign w_dec         = row_decode(i_row);

  assign o_col       = r_col;
  assign o_scan_done = w_sample && (r_col_idx == 2'd3);
  assign o_scan_kind = w_kind;
  assign o_scan_code = w_code;

  // Merge the current column's sample into the running scan result.
  always_comb begin
    w_kind = r_acc_kind;
    w_code = r_acc_code;
    if (w_sample) begin
      case (w_dec.kind)
        SCAN_NONE: begin
          w_kind = r_acc_kind;
        end
        SCAN_SINGLE: begin
          if (r_acc_kind == SCAN_NONE) begin
            w_kind = SCAN_SINGLE;
            w_code = {w_dec.idx, r_col_idx};
          end else begin
            w_kind = SCAN_MULTI;
          end
        end
        default: begin
          w_kind = SCAN_MULTI;
        end
      endcase
    end else begin
      w_kind = r_acc_kind;
    end
  end

  // Dwell counter, column stepping and accumulator; the column moves only
  // after its sample so the sample never sees a column edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase    <= '0;
      r_col_idx  <= 2'd0;
      r_col      <= 4'b0111;
      r_acc_kind <= SCAN_NONE;
      r_acc_code <= 4'd0;
    end else if (w_sample) begin
      r_phase   <= '0;
      r_col_idx <= w_col_idx_nxt;
      r_col     <= col_drive(w_col_idx_nxt);
      if (r_col_idx == 2'd3) begin
        r_acc_kind <= SCAN_NONE;
        r_acc_code <= 4'd0;
      end else begin
        r_acc_kind <= w_kind;
        r_acc_code <= w_code;
      end
    end else begin
      r_phase <= r_phase + PW'(1);
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// Keypad scanner top: debounce FSM over whole-scan results plus registered
// key event outputs.
module keypad_scanner
  import gomoku_kb_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 2,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic              kb_scan_clk,
  input  logic              rst,
  keypad_scanner_if.master  kb
);

  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0] CNT_TGT = CW'(DEBOUNCE_SCANS);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  localparam logic [1:0] S_IDLE       = KB_IDLE;
  localparam logic [1:0] S_DB_PRESS   = KB_DB_PRESS;
  localparam logic [1:0] S_HELD       = KB_HELD;
  localparam logic [1:0] S_DB_RELEASE = KB_DB_RELEASE;

  // Saturating increment for the debounce counter.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    if (v == {CW{1'b1}}) begin
      return v;
    end else begin
      return v + CW'(1);
    end
  endfunction

  logic          w_scan_done;
  scan_kind_e    w_scan_kind;
  key_code_t     w_scan_code;
  logic [3:0]    w_col;

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  key_code_t     r_cand;
  key_code_t     r_key_code;
  logic          r_key_valid;
  logic          r_key_down;

  logic [1:0]    w_state_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic [CW-1:0] w_inc;
  key_code_t     w_cand_nxt;
  key_code_t     w_code_nxt;
  logic          w_valid_nxt;
  logic          w_down_nxt;
  logic          w_single;
  logic          w_none;

  kb_column_scan #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_scan (
    .clk         (kb_scan_clk),
    .rst         (rst),
    .i_row       (kb.keyboard_row),
    .o_col       (w_col),
    .o_scan_done (w_scan_done),
    .o_scan_kind (w_scan_kind),
    .o_scan_code (w_scan_code)
  );

  assign kb.keyboard_col = w_col;
  assign kb.key_valid    = r_key_valid;
  assign kb.key_code     = r_key_code;
  assign kb.key_down     = r_key_down;

  assign w_inc    = sat_inc(r_cnt);
  assign w_single = (w_scan_kind == SCAN_SINGLE);
  assign w_none   = (w_scan_kind == SCAN_NONE);

  // Debounce decisions, taken once per completed scan.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cand_nxt  = r_cand;
    w_code_nxt  = r_key_code;
    w_valid_nxt = 1'b0;
    w_down_nxt  = r_key_down;
    if (w_scan_done) begin
      case (r_state)
        S_IDLE: begin
          if (w_single) begin
            w_cand_nxt = w_scan_code;
            w_cnt_nxt  = CNT_ONE;
            if (CNT_ONE >= CNT_TGT) begin
              w_code_nxt  = w_scan_code;
              w_valid_nxt = 1'b1;
              w_down_nxt  = 1'b1;
              w_state_nxt = S_HELD;
            end else begin
              w_state_nxt = S_DB_PRESS;
            end
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
        S_DB_PRESS: begin
          if (w_single && (w_scan_code == r_cand)) begin
            w_cnt_nxt = w_inc;
            if (w_inc >= CNT_TGT) begin
              w_code_nxt  = r_cand;
              w_valid_nxt = 1'b1;
              w_down_nxt  = 1'b1;
              w_state_nxt = S_HELD;
            end else begin
              w_state_nxt = S_DB_PRESS;
            end
          end else if (w_single) begin
            w_cand_nxt = w_scan_code;
            w_cnt_nxt  = CNT_ONE;
          end else begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_IDLE;
          end
        end
        S_HELD: begin
          if (w_single && (w_scan_code == r_key_code)) begin
            w_state_nxt = S_HELD;
          end else if (w_none) begin
            w_cnt_nxt = CNT_ONE;
            if (CNT_ONE >= CNT_TGT) begin
              w_cnt_nxt   = '0;
              w_down_nxt  = 1'b0;
              w_state_nxt = S_IDLE;
            end else begin
              w_state_nxt = S_DB_RELEASE;
            end
          end else begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_DB_RELEASE;
          end
        end
        S_DB_RELEASE: begin
          if (w_none) begin
            w_cnt_nxt = w_inc;
            if (w_inc >= CNT_TGT) begin
              w_cnt_nxt   = '0;
              w_down_nxt  = 1'b0;
              w_state_nxt = S_IDLE;
            end else begin
              w_state_nxt = S_DB_RELEASE;
            end
          end else if (w_single && (w_scan_code == r_key_code)) begin
            w_state_nxt = S_HELD;
          end else begin
            w_cnt_nxt = '0;
          end
        end
        default: begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
        end
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  // FSM state, debounce counter and registered key outputs.
  always_ff @(posedge kb_scan_clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_cand      <= 4'd0;
      r_key_code  <= 4'd0;
      r_key_valid <= 1'b0;
      r_key_down  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_cand      <= w_cand_nxt;
      r_key_code  <= w_code_nxt;
      r_key_valid <= w_valid_nxt;
      r_key_down  <= w_down_nxt;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a keypad model, directed vector
// tables, reset corner cases and randomized scans against a scan-level model.
module tb_keypad_scanner;

  localparam int SCAN_LEN = 12;
  localparam int DEB      = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] pressed = 16'h0000;
  logic [3:0]  row_drv;
  int          n_tests = 0;
  int          n_fail  = 0;

  keypad_scanner_if kb();

  keypad_scanner dut (
    .kb_scan_clk (clk),
    .rst         (rst),
    .kb          (kb)
  );

  always #5 clk = ~clk;

  // Keypad matrix: key k = {row, col} pulls its row low while its column is driven low.
  always_comb begin
    row_drv = 4'b1111;
    for (int k = 0; k < 16; k++) begin
      if (pressed[k] && (kb.keyboard_col[3 - (k % 4)] == 1'b0)) begin
        row_drv[3 - (k / 4)] = 1'b0;
      end
    end
  end
  assign kb.keyboard_row = row_drv;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scan-level reference: history of per-scan results (-1 none, -2 multi, else key).
  int        hist[$];
  bit        m_held;
  logic [3:0] m_code;

  task automatic model_reset();
    hist.delete();
    m_held = 1'b0;
    m_code = 4'h0;
  endtask

  task automatic model_step(input logic [15:0] mask, output bit pulse);
    int res;
    bit same;
    pulse = 1'b0;
    if ($countones(mask) == 0) res = -1;
    else if ($countones(mask) > 1) res = -2;
    else begin
      res = 0;
      for (int k = 0; k < 16; k++) if (mask[k]) res = k;
    end
    hist.push_back(res);
    if (hist.size() > DEB) void'(hist.pop_front());
    same = (hist.size() == DEB);
    for (int i = 0; i < hist.size(); i++) if (hist[i] != hist[0]) same = 1'b0;
    if (!m_held) begin
      if (same && hist[0] >= 0) begin
        m_held = 1'b1;
        m_code = 4'(hist[0]);
        pulse  = 1'b1;
      end
    end else begin
      if (same && hist[0] == -1) m_held = 1'b0;
    end
  endtask

  // One full scan period with a fixed key set; reports end-of-scan outputs.
  task automatic do_scan(input logic [15:0] mask, output logic v_end, output int n_pulse,
                         output logic d_end, output logic [3:0] c_end);
    pressed = mask;
    n_pulse = 0;
    for (int i = 0; i < SCAN_LEN; i++) begin
      @(posedge clk);
      #1;
      if (kb.key_valid === 1'b1) n_pulse++;
    end
    v_end = kb.key_valid;
    d_end = kb.key_down;
    c_end = kb.key_code;
  endtask

  task automatic apply_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_col"},   kb.keyboard_col, 4'b0111);
    check({tag, "_valid"}, kb.key_valid, 1'b0);
    check({tag, "_down"},  kb.key_down, 1'b0);
    check({tag, "_code"},  kb.key_code, 4'h0);
    @(negedge clk);
    rst = 1'b0;
    check({tag, "_col_post"}, kb.keyboard_col, 4'b0111);
    model_reset();
  endtask

  typedef struct {
    logic [15:0] mask;
    int          n_scans;
    int          pulse_at;
    logic        down_end;
    logic [3:0]  code_end;
  } vec_t;

  vec_t       vecs[10];
  logic [3:0] col_exp[12];
  logic       ve, de;
  int         np;
  logic [3:0] ce;
  bit         mp;
  logic [15:0] cur;

  initial begin
    // key A = bit 10, key 3 = bit 3, key 5 = bit 5
    vecs[0] = '{16'h0400, 20, 4, 1'b1, 4'hA};  // clean press, held
    vecs[1] = '{16'h0000,  3, 0, 1'b1, 4'hA};  // release not yet debounced
    vecs[2] = '{16'h0000,  1, 0, 1'b0, 4'hA};  // fourth quiet scan drops key_down
    vecs[3] = '{16'h0400,  4, 4, 1'b1, 4'hA};  // second press fires again
    vecs[4] = '{16'h0000,  4, 0, 1'b0, 4'hA};
    vecs[5] = '{16'h0408, 10, 0, 1'b0, 4'hA};  // two keys: rejected
    vecs[6] = '{16'h0400,  4, 4, 1'b1, 4'hA};  // 3 released, A accepted
    vecs[7] = '{16'h0000,  4, 0, 1'b0, 4'hA};
    vecs[8] = '{16'h0008,  4, 4, 1'b1, 4'h3};
    vecs[9] = '{16'h0000,  4, 0, 1'b0, 4'h3};
    col_exp = '{4'b0111, 4'b0111, 4'b1011, 4'b1011, 4'b1011, 4'b1101,
                4'b1101, 4'b1101, 4'b1110, 4'b1110, 4'b1110, 4'b0111};

    apply_reset("rst");

    // Column walk: three cycles per column after reset release.
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("col_walk_%0d", i), kb.keyboard_col, col_exp[i]);
    end

    for (int v = 0; v < 10; v++) begin
      for (int s = 1; s <= vecs[v].n_scans; s++) begin
        do_scan(vecs[v].mask, ve, np, de, ce);
        check($sformatf("vec%0d_scan%0d_valid", v, s), ve, (s == vecs[v].pulse_at) ? 1 : 0);
        check($sformatf("vec%0d_scan%0d_pulses", v, s), np, (s == vecs[v].pulse_at) ? 1 : 0);
      end
      check($sformatf("vec%0d_down", v), de, vecs[v].down_end);
      check($sformatf("vec%0d_code", v), ce, vecs[v].code_end);
    end

    // Bounce: key 3 for two scans, gone for one, repeated.
    for (int r = 0; r < 10; r++) begin
      for (int s = 0; s < 3; s++) begin
        do_scan((s < 2) ? 16'h0008 : 16'h0000, ve, np, de, ce);
        check($sformatf("bounce_%0d_%0d_pulses", r, s), np, 0);
        check($sformatf("bounce_%0d_%0d_down", r, s), de, 1'b0);
      end
    end
    check("bounce_code", ce, 4'h3);

    // Reset in the middle of debouncing key 5.
    for (int s = 0; s < 3; s++) begin
      do_scan(16'h0020, ve, np, de, ce);
      check($sformatf("midrst_pre_%0d_pulses", s), np, 0);
    end
    repeat (5) @(posedge clk);
    apply_reset("midrst");
    for (int s = 1; s <= 4; s++) begin
      do_scan(16'h0020, ve, np, de, ce);
      check($sformatf("midrst_post_%0d_pulses", s), np, (s == 4) ? 1 : 0);
    end
    check("midrst_code", ce, 4'h5);
    check("midrst_down", de, 1'b1);

    // Randomized scans against the scan-level reference.
    apply_reset("rnd_rst");
    cur = 16'h0000;
    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5, 6: cur = cur;
        7: cur = 16'h0000;
        8: cur = 16'h0001 << $urandom_range(0, 15);
        default: cur = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
      endcase
      model_step(cur, mp);
      do_scan(cur, ve, np, de, ce);
      check($sformatf("rnd%0d_valid", n), ve, mp);
      check($sformatf("rnd%0d_pulses", n), np, mp ? 1 : 0);
      check($sformatf("rnd%0d_down", n), de, m_held);
      check($sformatf("rnd%0d_code", n), ce, m_code);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
